// File: rtl/alu_accu_bank.sv
// alu_accu_bank
//   A bank of NUM_ACC accumulators sharing one ALU behind a valid/ready
//   command port. Single-cycle ops (ADD, SUB, AND, OR, XOR, LOAD, CLR) write
//   on the accept edge. MAC runs a DATA_WIDTH-cycle shift-add multiply and
//   then adds the truncated product into the selected accumulator.
//
// Ports
//   clk, rst           clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready  command handshake; in_ready is high only in IDLE
//   alu_opcode         operation, 3 LSBs decoded
//   acc_sel            target accumulator
//   input_data_0/1     operand A / operand B (B used by MAC only)
//   carry_in           carry/borrow in for ADD/SUB
//   out_valid          one-cycle pulse after each accumulator write
//   output_data        value just written, held between writes
//   carry_out          carry/borrow of that write
//   zero_out           output_data == 0
//   rd_sel/rd_data     combinational readback of acc[rd_sel]
module alu_accu_bank #(
    parameter int DATA_WIDTH   = 8,
    parameter int OPCODE_WIDTH = 3,
    parameter int NUM_ACC      = 4,
    parameter int SEL_WIDTH    = $clog2(NUM_ACC)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [OPCODE_WIDTH-1:0] alu_opcode,
    input  logic [SEL_WIDTH-1:0]    acc_sel,
    input  logic [DATA_WIDTH-1:0]   input_data_0,
    input  logic [DATA_WIDTH-1:0]   input_data_1,
    input  logic                    carry_in,
    output logic                    out_valid,
    output logic [DATA_WIDTH-1:0]   output_data,
    output logic                    carry_out,
    output logic                    zero_out,
    input  logic [SEL_WIDTH-1:0]    rd_sel,
    output logic [DATA_WIDTH-1:0]   rd_data
);

    localparam int               CNT_W    = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_LOAD = 3'b101;
    localparam logic [2:0] OP_MAC  = 3'b110;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] acc_q [NUM_ACC];

    // MAC working registers, loaded on the accept edge
    logic [DATA_WIDTH-1:0] mac_a_q;
    logic [DATA_WIDTH-1:0] mac_b_q;
    logic [SEL_WIDTH-1:0]  mac_sel_q;
    logic [DATA_WIDTH-1:0] prod_q;
    logic [CNT_W-1:0]      cnt_q;

    logic [2:0]            op;
    logic                  accept;
    logic                  mac_last;
    logic [DATA_WIDTH:0]   alu_res;
    logic [DATA_WIDTH-1:0] prod_next;
    logic [DATA_WIDTH:0]   mac_sum;

    // Single-cycle ALU. Bit DATA_WIDTH is the carry (ADD) or borrow (SUB):
    // a negative difference wraps in W+1 bits with the top bit set.
    function automatic logic [DATA_WIDTH:0] alu_result(
        input logic [2:0]            opc,
        input logic [DATA_WIDTH-1:0] acc,
        input logic [DATA_WIDTH-1:0] a,
        input logic                  cin
    );
        logic [DATA_WIDTH:0] acc_x;
        logic [DATA_WIDTH:0] a_x;
        logic [DATA_WIDTH:0] cin_x;
        logic [DATA_WIDTH:0] res;
        acc_x = {1'b0, acc};
        a_x   = {1'b0, a};
        cin_x = {{DATA_WIDTH{1'b0}}, cin};
        case (opc)
            OP_ADD:  res = acc_x + a_x + cin_x;
            OP_SUB:  res = acc_x - a_x - cin_x;
            OP_AND:  res = {1'b0, acc & a};
            OP_OR:   res = {1'b0, acc | a};
            OP_XOR:  res = {1'b0, acc ^ a};
            OP_LOAD: res = a_x;
            default: res = '0;   // CLR (MAC never takes this path)
        endcase
        return res;
    endfunction

    assign op       = alu_opcode[2:0];
    assign in_ready = (state_q == IDLE);
    assign accept   = in_valid && in_ready;
    assign mac_last = (state_q == MUL) && (cnt_q == CNT_LAST);
    assign alu_res  = alu_result(op, acc_q[acc_sel], input_data_0, carry_in);

    // One multiplier bit per MUL cycle, LSB first; the shifted A is
    // truncated to W bits so the product is naturally taken mod 2^W.
    assign prod_next = prod_q + (mac_b_q[cnt_q] ? (mac_a_q << cnt_q) : '0);
    assign mac_sum   = {1'b0, acc_q[mac_sel_q]} + {1'b0, prod_next};

    assign rd_data  = acc_q[rd_sel];
    assign zero_out = (output_data == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && op == OP_MAC) state_d = MUL;
            MUL:     if (mac_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_ACC; i++) acc_q[i] <= '0;
            mac_a_q     <= '0;
            mac_b_q     <= '0;
            mac_sel_q   <= '0;
            prod_q      <= '0;
            cnt_q       <= '0;
            out_valid   <= 1'b0;
            output_data <= '0;
            carry_out   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (accept) begin
                if (op == OP_MAC) begin
                    mac_a_q   <= input_data_0;
                    mac_b_q   <= input_data_1;
                    mac_sel_q <= acc_sel;
                    prod_q    <= '0;
                    cnt_q     <= '0;
                end else begin
                    acc_q[acc_sel] <= alu_res[DATA_WIDTH-1:0];
                    output_data    <= alu_res[DATA_WIDTH-1:0];
                    carry_out      <= alu_res[DATA_WIDTH];
                    out_valid      <= 1'b1;
                end
            end else if (state_q == MUL) begin
                prod_q <= prod_next;
                cnt_q  <= cnt_q + CNT_ONE;
                if (mac_last) begin
                    acc_q[mac_sel_q] <= mac_sum[DATA_WIDTH-1:0];
                    output_data      <= mac_sum[DATA_WIDTH-1:0];
                    carry_out        <= mac_sum[DATA_WIDTH];
                    out_valid        <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_accu_bank.sv
module tb_alu_accu_bank;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [2:0] alu_opcode = '0;
    logic [1:0] acc_sel = '0;
    logic [7:0] input_data_0 = '0;
    logic [7:0] input_data_1 = '0;
    logic       carry_in = 1'b0;
    logic       out_valid;
    logic [7:0] output_data;
    logic       carry_out;
    logic       zero_out;
    logic [1:0] rd_sel = '0;
    logic [7:0] rd_data;

    int errors = 0;
    int checks = 0;
    int model_acc [4];

    alu_accu_bank #(
        .DATA_WIDTH(8),
        .OPCODE_WIDTH(3),
        .NUM_ACC(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .alu_opcode(alu_opcode),
        .acc_sel(acc_sel),
        .input_data_0(input_data_0),
        .input_data_1(input_data_1),
        .carry_in(carry_in),
        .out_valid(out_valid),
        .output_data(output_data),
        .carry_out(carry_out),
        .zero_out(zero_out),
        .rd_sel(rd_sel),
        .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1);
    end

    // Reference model: plain integer arithmetic on the opcode rules.
    task automatic model_exec(input int op, input int sel, input int a, input int b,
                              input int cin, output int ev, output int ec);
        int cur;
        int s;
        cur = model_acc[sel];
        ec  = 0;
        case (op)
            0: begin s = cur + a + cin; ev = s % 256; ec = (s > 255); end
            1: begin s = cur - a - cin; ec = (s < 0); ev = (s + 512) % 256; end
            2: ev = cur & a;
            3: ev = cur | a;
            4: ev = cur ^ a;
            5: ev = a;
            6: begin s = cur + ((a * b) % 256); ev = s % 256; ec = (s > 255); end
            default: ev = 0;
        endcase
        model_acc[sel] = ev;
    endtask

    function automatic logic [10:0] expect_out(input int ev, input int ec);
        return {1'b1, 8'(ev), 1'(ec), 1'(ev == 0)};
    endfunction

    task automatic send(input int op, input int sel, input int a, input int b, input int cin);
        alu_opcode   = 3'(op);
        acc_sel      = 2'(sel);
        input_data_0 = 8'(a);
        input_data_1 = 8'(b);
        carry_in     = 1'(cin);
        in_valid     = 1'b1;
    endtask

    // Issues a MAC and waits (bounded) for its result. With junk=1 the
    // command inputs are scrambled and in_valid held high during MUL.
    task automatic run_mac(input int sel, input int a, input int b, input int cin,
                           input bit junk, output int lat, output int low);
        send(6, sel, a, b, cin);
        @(posedge clk); #1;
        lat = 1;
        low = 0;
        in_valid = junk;
        while (out_valid !== 1'b1 && lat < 20) begin
            if (in_ready === 1'b0) low++;
            if (junk) begin
                alu_opcode   = 3'($urandom_range(0, 7));
                acc_sel      = 2'($urandom_range(0, 3));
                input_data_0 = 8'($urandom);
                input_data_1 = 8'($urandom);
                carry_in     = 1'($urandom_range(0, 1));
            end
            @(posedge clk); #1;
            lat++;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) model_acc[i] = 0;
        #1 rst = 1'b0;
        #1;
        for (int s = 0; s < 4; s++) begin
            rd_sel = 2'(s);
            #1;
            checks++;
            if (rd_data !== 8'h00) begin
                errors++;
                $display("FAIL reset_rd_data[%0d]: got %h required 00", s, rd_data);
            end
        end
        checks++;
        if ({in_ready, out_valid, zero_out, output_data, carry_out} !== {3'b101, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL reset_outputs: got rdy=%b ov=%b z=%b d=%h c=%b required 1 0 1 00 0",
                     in_ready, out_valid, zero_out, output_data, carry_out);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_mac();
        int bad;
        send(6, 0, 'h0C, 'h0B, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_mac_busy: in_ready=%b required 0", in_ready);
        end
        #1 rst = 1'b0;
        #1;
        rd_sel = 2'd0;
        #1;
        checks++;
        if ({in_ready, out_valid, rd_data} !== {2'b10, 8'h00}) begin
            errors++;
            $display("FAIL mid_mac_abort: got rdy=%b ov=%b acc0=%h required 1 0 00",
                     in_ready, out_valid, rd_data);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        bad = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0 || in_ready !== 1'b1 || rd_data !== 8'h00) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL mid_mac_after_release: %0d bad cycles, required 0", bad);
        end
    endtask

    task automatic test_load_add();
        int ev, ec;
        send(5, 1, 'hF0, 0, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        model_exec(5, 1, 'hF0, 0, 0, ev, ec);
        checks++;
        if ({out_valid, output_data, carry_out, zero_out} !== {1'b1, 8'hF0, 2'b00}) begin
            errors++;
            $display("FAIL load_acc1: got ov=%b d=%h c=%b required 1 f0 0", out_valid, output_data, carry_out);
        end
        send(0, 1, 'h20, 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        model_exec(0, 1, 'h20, 0, 1, ev, ec);
        checks++;
        if ({out_valid, output_data, carry_out, zero_out} !== {1'b1, 8'h11, 2'b10}) begin
            errors++;
            $display("FAIL add_carry: got ov=%b d=%h c=%b z=%b required 1 11 1 0",
                     out_valid, output_data, carry_out, zero_out);
        end
        @(posedge clk); #1;
        checks++;
        if ({out_valid, output_data, carry_out} !== {1'b0, 8'h11, 1'b1}) begin
            errors++;
            $display("FAIL hold_after_pulse: got ov=%b d=%h c=%b required 0 11 1", out_valid, output_data, carry_out);
        end
        for (int s = 0; s < 4; s++) begin
            rd_sel = 2'(s);
            #1;
            checks++;
            if (rd_data !== 8'(model_acc[s])) begin
                errors++;
                $display("FAIL bank_after_add[%0d]: got %h required %h", s, rd_data, 8'(model_acc[s]));
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_sub_xor();
        int ev, ec;
        send(1, 2, 'h01, 0, 0);
        @(posedge clk); #1;
        model_exec(1, 2, 'h01, 0, 0, ev, ec);
        send(4, 2, 'hFF, 0, 0);
        checks++;
        if ({out_valid, output_data, carry_out, zero_out} !== {1'b1, 8'hFF, 2'b10}) begin
            errors++;
            $display("FAIL sub_borrow: got ov=%b d=%h c=%b z=%b required 1 ff 1 0",
                     out_valid, output_data, carry_out, zero_out);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        model_exec(4, 2, 'hFF, 0, 0, ev, ec);
        checks++;
        if ({out_valid, output_data, carry_out, zero_out} !== {1'b1, 8'h00, 2'b01}) begin
            errors++;
            $display("FAIL xor_zero: got ov=%b d=%h c=%b z=%b required 1 00 0 1",
                     out_valid, output_data, carry_out, zero_out);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_mac();
        int ev, ec, lat, low;
        send(5, 3, 'h05, 0, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        model_exec(5, 3, 'h05, 0, 0, ev, ec);
        run_mac(3, 'h0C, 'h0B, 0, 1'b0, lat, low);
        model_exec(6, 3, 'h0C, 'h0B, 0, ev, ec);
        checks++;
        if (lat != 9 || low != 8) begin
            errors++;
            $display("FAIL mac_timing: latency=%0d ready_low=%0d required 9 8", lat, low);
        end
        checks++;
        if ({out_valid, output_data, carry_out, in_ready} !== {1'b1, 8'h89, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL mac_result: got ov=%b d=%h c=%b rdy=%b required 1 89 0 1",
                     out_valid, output_data, carry_out, in_ready);
        end
        run_mac(3, 'hFF, 'hFF, 0, 1'b0, lat, low);
        model_exec(6, 3, 'hFF, 'hFF, 0, ev, ec);
        checks++;
        if ({out_valid, output_data, carry_out} !== {1'b1, 8'h8A, 1'b0}) begin
            errors++;
            $display("FAIL mac_ff_ff: got ov=%b d=%h c=%b required 1 8a 0", out_valid, output_data, carry_out);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_mac_overflow();
        int ev, ec, lat, low;
        send(5, 0, 'hF0, 0, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        model_exec(5, 0, 'hF0, 0, 0, ev, ec);
        run_mac(0, 'h10, 'h02, 1, 1'b0, lat, low);
        model_exec(6, 0, 'h10, 'h02, 1, ev, ec);
        checks++;
        if ({out_valid, output_data, carry_out, zero_out} !== {1'b1, 8'h10, 2'b10}) begin
            errors++;
            $display("FAIL mac_overflow: got ov=%b d=%h c=%b z=%b required 1 10 1 0",
                     out_valid, output_data, carry_out, zero_out);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int ops [4] = '{5, 0, 3, 2};
        int as  [4] = '{'h3C, 'h7F, 'h81, 'h0F};
        int cis [4] = '{0, 1, 0, 0};
        int ev, ec;
        logic [10:0] exp_v;
        send(ops[0], 0, as[0], 0, cis[0]);
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            model_exec(ops[i], i, as[i], 0, cis[i], ev, ec);
            exp_v = expect_out(ev, ec);
            if (i < 3) send(ops[i+1], i + 1, as[i+1], 0, cis[i+1]);
            else in_valid = 1'b0;
            checks++;
            if ({out_valid, output_data, carry_out, zero_out} !== exp_v) begin
                errors++;
                $display("FAIL b2b_out[%0d]: got %b required %b", i, {out_valid, output_data, carry_out, zero_out}, exp_v);
            end
            rd_sel = 2'(i);
            #1;
            checks++;
            if (rd_data !== 8'(ev)) begin
                errors++;
                $display("FAIL b2b_rd_new[%0d]: got %h required %h", i, rd_data, 8'(ev));
            end
            if (i < 3) begin
                rd_sel = 2'(i + 1);
                #1;
                checks++;
                if (rd_data !== 8'(model_acc[i+1])) begin
                    errors++;
                    $display("FAIL b2b_rd_old[%0d]: got %h required %h", i + 1, rd_data, 8'(model_acc[i+1]));
                end
            end
            @(posedge clk); #1;
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end_pulse: out_valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_hold_during_mul();
        int ev, ec, bad, old2;
        old2 = model_acc[2];
        rd_sel = 2'd2;
        send(6, 1, 'h03, 'h05, 0);
        @(posedge clk); #1;
        send(5, 2, 'h55, 0, 0);
        bad = 0;
        for (int c = 1; c <= 8; c++) begin
            if (out_valid !== 1'b0 || in_ready !== 1'b0 || rd_data !== 8'(old2)) bad++;
            @(posedge clk); #1;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL hold_mul_ignored: %0d bad cycles, required 0", bad);
        end
        model_exec(6, 1, 'h03, 'h05, 0, ev, ec);
        checks++;
        if ({out_valid, output_data, carry_out, zero_out, in_ready, rd_data} !==
            {expect_out(ev, ec), 1'b1, 8'(old2)}) begin
            errors++;
            $display("FAIL hold_mac_done: got ov=%b d=%h rdy=%b acc2=%h required 1 %h 1 %h",
                     out_valid, output_data, in_ready, rd_data, 8'(ev), 8'(old2));
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        model_exec(5, 2, 'h55, 0, 0, ev, ec);
        checks++;
        if ({out_valid, output_data, rd_data} !== {1'b1, 8'h55, 8'h55}) begin
            errors++;
            $display("FAIL hold_load_taken: got ov=%b d=%h acc2=%h required 1 55 55", out_valid, output_data, rd_data);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        int op, sel, a, b, cin, ev, ec, lat, low, rs;
        logic [10:0] exp_v;
        for (int n = 0; n < 150; n++) begin
            op  = $urandom_range(0, 7);
            sel = $urandom_range(0, 3);
            a   = $urandom_range(0, 255);
            b   = $urandom_range(0, 255);
            cin = $urandom_range(0, 1);
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
                checks++;
                if (out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL rnd_idle[%0d]: out_valid=%b required 0", n, out_valid);
                end
            end
            if (op == 6) begin
                run_mac(sel, a, b, cin, 1'b1, lat, low);
                checks++;
                if (lat != 9) begin
                    errors++;
                    $display("FAIL rnd_mac_latency[%0d]: got %0d required 9", n, lat);
                end
            end else begin
                send(op, sel, a, b, cin);
                @(posedge clk); #1;
                in_valid = 1'b0;
            end
            model_exec(op, sel, a, b, cin, ev, ec);
            exp_v = expect_out(ev, ec);
            checks++;
            if ({out_valid, output_data, carry_out, zero_out} !== exp_v) begin
                errors++;
                $display("FAIL rnd_out[%0d] op=%0d sel=%0d a=%h b=%h cin=%0d: got %b required %b",
                         n, op, sel, a, b, cin, {out_valid, output_data, carry_out, zero_out}, exp_v);
            end
            rs = $urandom_range(0, 3);
            rd_sel = 2'(rs);
            #1;
            checks++;
            if (rd_data !== 8'(model_acc[rs])) begin
                errors++;
                $display("FAIL rnd_rd[%0d] sel=%0d: got %h required %h", n, rs, rd_data, 8'(model_acc[rs]));
            end
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_reset_mid_mac();
        test_load_add();
        test_sub_xor();
        test_mac();
        test_mac_overflow();
        test_back_to_back();
        test_hold_during_mul();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
